// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_BITS data bits (LSB first), optional parity, 1 or 2 stop bits.
// Latency: a word accepted at edge c drives its start bit from the first enable tick strictly after c.
// Backpressure: one-entry holding buffer; ready=0 while it is full, and a load then is dropped with an error pulse.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    // Reject frame formats the line protocol does not define.
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
            $error("uart_tx_frame: DATA_BITS must be 5..9 and STOP_BITS 1 or 2");
        end
    endgenerate

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    // stop_cnt value that marks the final stop bit
    localparam logic              LAST_STOP = (STOP_BITS == 2);
    localparam logic              ODD_PAR   = (PARITY_ODD != 0);
    localparam logic              USE_PAR   = (PARITY_EN != 0);

    // The state names the bit currently being driven on the line.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   buf_q, buf_d;         // holding buffer
    logic                   ready_q, ready_d;     // holding buffer empty
    logic [DATA_BITS-1:0]   shift_q, shift_d;     // word of the frame in flight
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   line_q, line_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic [CNT_W-1:0]       bit_nxt;
    logic                   parity_bit;

    assign bit_nxt = bit_cnt_q + CNT_W'(1);

    // Parity comes from the frame's own copy so later loads cannot disturb it.
    assign parity_bit = (^shift_q) ^ ODD_PAR;

    // State register: reset aborts any frame, drops the buffered word and idles the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            ready_q    <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            line_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            ready_q    <= ready_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            line_q     <= line_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Next state: host handshake every cycle, line sequencing only on enable ticks.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ready_d    = ready_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        line_d     = line_q;
        done_d     = 1'b0;
        error_d    = 1'b0;

        // A load into a full buffer is discarded; the buffered word is kept.
        // Accept and drain never coincide: draining needs a full buffer, which blocks acceptance.
        if (load) begin
            if (ready_q) begin
                buf_d   = data_in;
                ready_d = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!ready_q) begin
                        line_d  = 1'b0;
                        shift_d = buf_q;
                        ready_d = 1'b1;
                        state_d = S_START;
                    end else begin
                        line_d = 1'b1;
                    end
                end
                S_START: begin
                    line_d    = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q != LAST_BIT) begin
                        line_d    = shift_q[bit_nxt];
                        bit_cnt_d = bit_nxt;
                    end else if (USE_PAR) begin
                        line_d  = parity_bit;
                        state_d = S_PARITY;
                    end else begin
                        line_d     = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
                    end
                end
                S_PARITY: begin
                    line_d     = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (stop_cnt_q != LAST_STOP) begin
                        line_d     = 1'b1;
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        // A waiting word starts right away so frames abut with no idle bit.
                        if (!ready_q) begin
                            line_d  = 1'b0;
                            shift_d = buf_q;
                            ready_d = 1'b1;
                            state_d = S_START;
                        end else begin
                            line_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    line_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign data_out = line_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame across 8N1, 7E1, 7O1 and 8N2 instances.
// Each task drives one scenario and compares line/handshake outputs cycle by cycle.
// Outputs are sampled 1 time unit after the rising edge.
module tb_uart_tx_frame;

    logic clk;
    logic reset;

    // 8N1
    logic       en0, ld0, rdy0, dout0, busy0, done0, err0;
    logic [7:0] din0;
    // 7E1 and 7O1 share stimulus
    logic       en1, ld1;
    logic [6:0] din1;
    logic       rdy1, dout1, busy1, done1, err1;
    logic       rdy2, dout2, busy2, done2, err2;
    // 8N2
    logic       en3, ld3, rdy3, dout3, busy3, done3, err3;
    logic [7:0] din3;

    int n_checks;
    int n_fail;

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .load(ld0), .data_in(din0),
        .ready(rdy0), .data_out(dout0), .busy(busy0), .done(done0), .error(err0));

    uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .load(ld1), .data_in(din1),
        .ready(rdy1), .data_out(dout1), .busy(busy1), .done(done1), .error(err1));

    uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .enable(en1), .load(ld1), .data_in(din1),
        .ready(rdy2), .data_out(dout2), .busy(busy2), .done(done2), .error(err2));

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .enable(en3), .load(ld3), .data_in(din3),
        .ready(rdy3), .data_out(dout3), .busy(busy3), .done(done3), .error(err3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        // {data_out, busy, ready, done, error}
        n_checks++;
        if ({dout0, busy0, rdy0, done0, err0} !== 5'b10100) begin
            n_fail++; $display("FAIL reset_dut0: got %b expected 10100", {dout0, busy0, rdy0, done0, err0});
        end
        n_checks++;
        if ({dout1, busy1, rdy1, done1, err1} !== 5'b10100) begin
            n_fail++; $display("FAIL reset_dut1: got %b expected 10100", {dout1, busy1, rdy1, done1, err1});
        end
        n_checks++;
        if ({dout2, busy2, rdy2, done2, err2} !== 5'b10100) begin
            n_fail++; $display("FAIL reset_dut2: got %b expected 10100", {dout2, busy2, rdy2, done2, err2});
        end
        n_checks++;
        if ({dout3, busy3, rdy3, done3, err3} !== 5'b10100) begin
            n_fail++; $display("FAIL reset_dut3: got %b expected 10100", {dout3, busy3, rdy3, done3, err3});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_8n1();
        logic [9:0] exp_f;
        exp_f = 10'b1101001010;   // 0xA5: 0,1,0,1,0,0,1,0,1,1
        en0 = 1'b1; ld0 = 1'b1; din0 = 8'hA5;
        step();
        ld0 = 1'b0;
        n_checks++;
        if ({dout0, busy0, rdy0} !== 3'b100) begin
            n_fail++; $display("FAIL a5_accept: {line,busy,ready}=%b expected 100", {dout0, busy0, rdy0});
        end
        for (int t = 1; t <= 10; t++) begin
            step();
            n_checks++;
            if ({dout0, busy0, done0} !== {exp_f[t-1], 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL a5_bit%0d: {line,busy,done}=%b expected %b", t, {dout0, busy0, done0}, {exp_f[t-1], 1'b1, 1'b0});
            end
        end
        step();
        n_checks++;
        if ({dout0, busy0, done0, rdy0} !== 4'b1011) begin
            n_fail++; $display("FAIL a5_end: {line,busy,done,ready}=%b expected 1011", {dout0, busy0, done0, rdy0});
        end
        step();
        n_checks++;
        if (done0 !== 1'b0) begin
            n_fail++; $display("FAIL a5_done_width: done=%b expected 0", done0);
        end
    endtask

    task automatic test_parity();
        logic [9:0] exp_even, exp_odd;
        exp_even = 10'b1100001110;  // 0x07 7E1: parity 1
        exp_odd  = 10'b1000001110;  // 0x07 7O1: parity 0
        en1 = 1'b1; ld1 = 1'b1; din1 = 7'h07;
        step();
        ld1 = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            n_checks++;
            if (dout1 !== exp_even[t-1]) begin
                n_fail++; $display("FAIL even_bit%0d: line=%b expected %b", t, dout1, exp_even[t-1]);
            end
            n_checks++;
            if (dout2 !== exp_odd[t-1]) begin
                n_fail++; $display("FAIL odd_bit%0d: line=%b expected %b", t, dout2, exp_odd[t-1]);
            end
        end
        step();
        n_checks++;
        if ({done1, busy1, done2, busy2} !== 4'b1010) begin
            n_fail++; $display("FAIL parity_end: {done1,busy1,done2,busy2}=%b expected 1010", {done1, busy1, done2, busy2});
        end
        en1 = 1'b0;
    endtask

    task automatic test_slow_enable();
        logic [9:0] exp_f;
        exp_f = 10'b1001111000;    // 0x3C: 0,0,0,1,1,1,1,0,0,1
        en0 = 1'b0; ld0 = 1'b1; din0 = 8'h3C;
        step();
        ld0 = 1'b0;
        n_checks++;
        if ({dout0, rdy0} !== 2'b10) begin
            n_fail++; $display("FAIL slow_accept: {line,ready}=%b expected 10", {dout0, rdy0});
        end
        for (int k = 0; k < 176; k++) begin
            logic exp_line;
            en0 = ((k % 16) == 0);
            step();
            en0 = 1'b0;
            exp_line = (k < 160) ? exp_f[k/16] : 1'b1;
            n_checks++;
            if (dout0 !== exp_line) begin
                n_fail++; $display("FAIL slow_line_c%0d: line=%b expected %b", k, dout0, exp_line);
            end
            n_checks++;
            if (done0 !== (k == 160)) begin
                n_fail++; $display("FAIL slow_done_c%0d: done=%b expected %b", k, done0, (k == 160));
            end
        end
        en0 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [20:0] seq;
        logic        exp_line;
        seq = {1'b1, 10'b1001000100, 10'b1000100010};   // 0x11 frame, 0x22 frame, idle
        en0 = 1'b1;
        for (int t = 0; t <= 22; t++) begin
            ld0 = (t == 0) || (t == 2) || (t == 4);
            din0 = (t == 0) ? 8'h11 : (t == 2) ? 8'h22 : 8'h33;
            step();
            ld0 = 1'b0;
            exp_line = (t >= 1 && t <= 21) ? seq[t-1] : 1'b1;
            n_checks++;
            if (dout0 !== exp_line) begin
                n_fail++; $display("FAIL b2b_line_t%0d: line=%b expected %b", t, dout0, exp_line);
            end
            n_checks++;
            if (done0 !== (t == 11 || t == 21)) begin
                n_fail++; $display("FAIL b2b_done_t%0d: done=%b expected %b", t, done0, (t == 11 || t == 21));
            end
            n_checks++;
            if (err0 !== (t == 4)) begin
                n_fail++; $display("FAIL b2b_error_t%0d: error=%b expected %b", t, err0, (t == 4));
            end
            if (t == 2 || t == 4) begin
                n_checks++;
                if (rdy0 !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_ready_t%0d: ready=%b expected 0", t, rdy0);
                end
            end
            if (t == 11) begin
                n_checks++;
                if ({rdy0, busy0} !== 2'b11) begin
                    n_fail++; $display("FAIL b2b_drain: {ready,busy}=%b expected 11", {rdy0, busy0});
                end
            end
        end
    endtask

    task automatic test_two_stop();
        logic [22:0] seq;
        logic        exp_line;
        int          n_done;
        seq = {1'b1, 11'b11000011110, 11'b11010101010};  // 0x55 frame, 0x0F frame, idle
        n_done = 0;
        en3 = 1'b1;
        for (int t = 0; t <= 24; t++) begin
            ld3 = (t == 0) || (t == 2);
            din3 = (t == 0) ? 8'h55 : 8'h0F;
            step();
            ld3 = 1'b0;
            if (done3 === 1'b1) n_done++;
            exp_line = (t >= 1 && t <= 23) ? seq[t-1] : 1'b1;
            n_checks++;
            if (dout3 !== exp_line) begin
                n_fail++; $display("FAIL stop2_line_t%0d: line=%b expected %b", t, dout3, exp_line);
            end
            n_checks++;
            if (done3 !== (t == 12 || t == 23)) begin
                n_fail++; $display("FAIL stop2_done_t%0d: done=%b expected %b", t, done3, (t == 12 || t == 23));
            end
            if (t == 12) begin
                n_checks++;
                if (busy3 !== 1'b1) begin
                    n_fail++; $display("FAIL stop2_gap: busy=%b expected 1", busy3);
                end
            end
        end
        n_checks++;
        if (n_done != 2) begin
            n_fail++; $display("FAIL stop2_done_count: done pulses=%0d expected 2", n_done);
        end
        n_checks++;
        if (err3 !== 1'b0) begin
            n_fail++; $display("FAIL stop2_error: error=%b expected 0", err3);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp_f;
        exp_f = 10'b1100101100;    // 0x96: 0,0,1,1,0,1,0,0,1,1
        en0 = 1'b1; ld0 = 1'b1; din0 = 8'h00;
        step();                    // accepted
        ld0 = 1'b0;
        step();                    // start bit
        ld0 = 1'b1; din0 = 8'h5A;
        step();                    // D0, 0x5A buffered
        ld0 = 1'b0;
        repeat (4) step();         // D1..D4
        n_checks++;
        if ({dout0, busy0, rdy0} !== 3'b010) begin
            n_fail++; $display("FAIL mid_pre: {line,busy,ready}=%b expected 010", {dout0, busy0, rdy0});
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({dout0, busy0, rdy0, done0} !== 4'b1010) begin
            n_fail++; $display("FAIL mid_reset: {line,busy,ready,done}=%b expected 1010", {dout0, busy0, rdy0, done0});
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if ({dout0, busy0, done0} !== 3'b100) begin
                n_fail++; $display("FAIL mid_after_c%0d: {line,busy,done}=%b expected 100", c, {dout0, busy0, done0});
            end
        end
        ld0 = 1'b1; din0 = 8'h96;
        step();
        ld0 = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step();
            n_checks++;
            if (dout0 !== exp_f[t-1]) begin
                n_fail++; $display("FAIL mid_reload_bit%0d: line=%b expected %b", t, dout0, exp_f[t-1]);
            end
        end
        step();
        n_checks++;
        if ({done0, busy0, dout0} !== 3'b101) begin
            n_fail++; $display("FAIL mid_reload_end: {done,busy,line}=%b expected 101", {done0, busy0, dout0});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        en0 = 1'b0; ld0 = 1'b0; din0 = '0;
        en1 = 1'b0; ld1 = 1'b0; din1 = '0;
        en3 = 1'b0; ld3 = 1'b0; din3 = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_slow_enable();
        test_back_to_back();
        test_two_stop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
